// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: fixed state encoding and
// the width rule for the single shared down-counter.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_UPDATE    = 3'd5,
        ST_FAULT     = 3'd6
    } pll_state_e;

    // Wide enough to hold the longest phase length without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous PLL LOCK output.
module sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Bring-up, lock qualification, retry and dynamic-delay sequencing for one
// SB_PLL40_2_PAD; runs on the free-running reference clock.
//
// state     | meaning
// IDLE      | PLL held in reset, bypassed; waits for enable
// RESET     | RESETB low for RESET_CYCLES
// WAIT_LOCK | RESETB released, waiting for lock_s or timeout
// STABLE    | lock_s must stay high for LOCK_STABLE_CYCLES
// RUN       | clocks usable (clk_ok=1); accepts delay requests
// UPDATE    | one cycle: load DYNAMICDELAY, pulse delay_ack
// FAULT     | retries exhausted; sticky until enable drops
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic [7:0] pll_dynamicdelay,
    input  logic       delay_req,
    input  logic [7:0] delay_val,
    output logic       delay_ack,
    output logic       clk_ok,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CW = cnt_width(RESET_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RESET_LOAD   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LOAD  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    pll_state_e    state_q;
    pll_state_e    state_d;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] retry_q;
    logic [RW-1:0] retry_d;
    logic [RW-1:0] retry_inc;
    logic          lock_s;
    logic          cnt_done;
    logic          retry_exhausted;

    sync2 u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    assign cnt_done        = (cnt_q == '0);
    assign retry_inc       = retry_q + RW'(1);
    assign retry_exhausted = (retry_inc == RETRY_MAX);
    assign state           = state_q;

    // Counter reload value on entry to each state; unused states park at 0.
    function automatic logic [CW-1:0] load_for(input pll_state_e s);
        case (s)
            ST_RESET:     return RESET_LOAD;
            ST_WAIT_LOCK: return TIMEOUT_LOAD;
            ST_STABLE:    return STABLE_LOAD;
            default:      return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RESET;
                retry_d = '0;
            end
            ST_RESET: begin
                if (cnt_done) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_done) begin
                    retry_d = retry_inc;
                    state_d = retry_exhausted ? ST_FAULT : ST_RESET;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_done) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    retry_d = retry_inc;
                    state_d = retry_exhausted ? ST_FAULT : ST_RESET;
                end else if (delay_req) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: state_d = ST_STABLE;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            retry_d = retry_q;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            retry_q          <= '0;
            pll_resetb       <= 1'b0;
            pll_bypass       <= 1'b1;
            pll_dynamicdelay <= 8'h00;
            delay_ack        <= 1'b0;
            clk_ok           <= 1'b0;
            fault            <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            if (state_d != state_q) begin
                cnt_q <= load_for(state_d);
            end else if (!cnt_done) begin
                cnt_q <= cnt_q - CW'(1);
            end
            pll_resetb <= state_d inside {ST_WAIT_LOCK, ST_STABLE, ST_RUN, ST_UPDATE};
            pll_bypass <= state_d inside {ST_IDLE, ST_FAULT};
            clk_ok     <= (state_d == ST_RUN);
            fault      <= (state_d == ST_FAULT);
            delay_ack  <= (state_d == ST_UPDATE);
            if (state_d == ST_UPDATE) begin
                pll_dynamicdelay <= delay_val;
            end
        end
    end

endmodule
